// File: rtl/neuron_iter_if.sv
// Handshake and strobe bundle between the iteration scheduler and the shared-MAC neuron datapath.
interface neuron_iter_if #(
  parameter int SW = 2,
  parameter int IW = 4
) ();
  logic          start;
  logic          converged;
  logic          init;
  logic          mac_clr;
  logic          mac_en;
  logic          wb_en;
  logic          commit;
  logic [SW-1:0] neuron_sel;
  logic [SW-1:0] term_sel;
  logic [IW-1:0] iter_cnt;
  logic          busy;
  logic          done;
  logic          timeout;

  modport master (
    input  start, converged,
    output init, mac_clr, mac_en, wb_en, commit,
    output neuron_sel, term_sel, iter_cnt, busy, done, timeout
  );

  modport slave (
    output start, converged,
    input  init, mac_clr, mac_en, wb_en, commit,
    input  neuron_sel, term_sel, iter_cnt, busy, done, timeout
  );
endinterface

// File: rtl/neuron_iter_scheduler.sv
// Sequencer for a time-multiplexed Maxnet datapath: walks neurons and terms through one shared MAC,
// commits each iteration and stops on convergence or on the iteration cap.
module neuron_iter_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int MAX_ITER  = 15,
  parameter int SW        = $clog2(N_NEURONS),
  parameter int IW        = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  neuron_iter_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_CLR    = 3'd2,
    ST_ACC    = 3'd3,
    ST_WB     = 3'd4,
    ST_COMMIT = 3'd5,
    ST_CHECK  = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam logic [SW-1:0] IDX_ZERO  = {SW{1'b0}};
  localparam logic [SW-1:0] IDX_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] IDX_LAST  = SW'(N_NEURONS - 1);
  localparam logic [IW-1:0] ITER_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] ITER_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] ITER_CAP  = IW'(MAX_ITER);

  state_t        state_r, next_state_s;
  logic [SW-1:0] neuron_sel_r, neuron_next_s;
  logic [SW-1:0] term_sel_r, term_next_s;
  logic [IW-1:0] iter_cnt_r, iter_next_s;
  logic          timeout_r, timeout_next_s;
  logic          init_r, mac_clr_r, mac_en_r, wb_en_r, commit_r, busy_r, done_r;

  // Next-state and next-index computation; INIT entry and residence clear the run bookkeeping.
  always_comb begin
    next_state_s   = state_r;
    neuron_next_s  = neuron_sel_r;
    term_next_s    = term_sel_r;
    iter_next_s    = iter_cnt_r;
    timeout_next_s = timeout_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s   = ST_INIT;
          neuron_next_s  = IDX_ZERO;
          term_next_s    = IDX_ZERO;
          iter_next_s    = ITER_ZERO;
          timeout_next_s = 1'b0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        neuron_next_s  = IDX_ZERO;
        term_next_s    = IDX_ZERO;
        iter_next_s    = ITER_ZERO;
        timeout_next_s = 1'b0;
        if (bus.start) begin
          next_state_s = ST_INIT;
        end else begin
          next_state_s = ST_CLR;
        end
      end
      ST_CLR: begin
        term_next_s  = IDX_ZERO;
        next_state_s = ST_ACC;
      end
      ST_ACC: begin
        if (term_sel_r == IDX_LAST) begin
          term_next_s  = IDX_ZERO;
          next_state_s = ST_WB;
        end else begin
          term_next_s  = term_sel_r + IDX_ONE;
          next_state_s = ST_ACC;
        end
      end
      ST_WB: begin
        if (neuron_sel_r == IDX_LAST) begin
          next_state_s = ST_COMMIT;
        end else begin
          neuron_next_s = neuron_sel_r + IDX_ONE;
          next_state_s  = ST_CLR;
        end
      end
      ST_COMMIT: begin
        iter_next_s   = iter_cnt_r + ITER_ONE;
        neuron_next_s = IDX_ZERO;
        next_state_s  = ST_CHECK;
      end
      ST_CHECK: begin
        // Convergence takes precedence over the cap in the same cycle.
        if (bus.converged) begin
          next_state_s = ST_DONE;
        end else if (iter_cnt_r == ITER_CAP) begin
          next_state_s   = ST_DONE;
          timeout_next_s = 1'b1;
        end else begin
          next_state_s = ST_CLR;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, index and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      neuron_sel_r <= IDX_ZERO;
      term_sel_r   <= IDX_ZERO;
      iter_cnt_r   <= ITER_ZERO;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      neuron_sel_r <= neuron_next_s;
      term_sel_r   <= term_next_s;
      iter_cnt_r   <= iter_next_s;
      timeout_r    <= timeout_next_s;
    end
  end

  // Strobes are registered decodes of the upcoming state, so they track the present state glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_r    <= 1'b0;
      mac_clr_r <= 1'b0;
      mac_en_r  <= 1'b0;
      wb_en_r   <= 1'b0;
      commit_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      init_r    <= (next_state_s == ST_INIT);
      mac_clr_r <= (next_state_s == ST_CLR);
      mac_en_r  <= (next_state_s == ST_ACC);
      wb_en_r   <= (next_state_s == ST_WB);
      commit_r  <= (next_state_s == ST_COMMIT);
      busy_r    <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
      done_r    <= (next_state_s == ST_DONE);
    end
  end

  assign bus.init       = init_r;
  assign bus.mac_clr    = mac_clr_r;
  assign bus.mac_en     = mac_en_r;
  assign bus.wb_en      = wb_en_r;
  assign bus.commit     = commit_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.timeout    = timeout_r;
  assign bus.neuron_sel = neuron_sel_r;
  assign bus.term_sel   = term_sel_r;
  assign bus.iter_cnt   = iter_cnt_r;

endmodule

// File: tb/tb_neuron_iter_scheduler.sv
// Bench for neuron_iter_scheduler: cycle-position model of a run compared every cycle, plus literal run checks.
module tb_neuron_iter_scheduler;
  localparam int N    = 4;
  localparam int MAXI = 15;
  localparam int SW   = $clog2(N);
  localparam int IW   = $clog2(MAXI + 1);
  localparam int PPN  = N + 2;
  localparam int BODY = N * PPN;
  localparam int ILEN = BODY + 2;
  localparam int VW   = 8 + 2 * SW + IW;

  logic clk = 1'b0;
  logic rst;

  neuron_iter_if #(.SW(SW), .IW(IW)) b ();

  neuron_iter_scheduler #(.N_NEURONS(N), .MAX_ITER(MAXI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  // Run model: where in the run we are, expressed as a cycle position inside the iteration.
  typedef enum int {M_IDLE, M_INIT, M_RUN, M_DONE} mode_t;
  mode_t m_mode;
  int    m_p, m_iter;
  bit    m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE; m_p <= 0; m_iter <= 0; m_to <= 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (b.start) begin m_mode <= M_INIT; m_iter <= 0; m_to <= 1'b0; end
        M_INIT: if (!b.start) begin m_mode <= M_RUN; m_p <= 0; end
        M_RUN: begin
          if (m_p == ILEN - 1) begin
            if (b.converged) m_mode <= M_DONE;
            else if (m_iter == MAXI) begin m_mode <= M_DONE; m_to <= 1'b1; end
            else m_p <= 0;
          end else begin
            m_p <= m_p + 1;
            if (m_p == ILEN - 2) m_iter <= m_iter + 1;
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  function automatic logic [VW-1:0] model_vec();
    bit ini = 0, clr = 0, en = 0, wb = 0, cm = 0, bsy = 0, dn = 0;
    int nb = 0, tm = 0;
    case (m_mode)
      M_INIT: begin ini = 1; bsy = 1; end
      M_RUN: begin
        bsy = 1;
        if (m_p < BODY) begin
          nb = m_p / PPN;
          if (m_p % PPN == 0) clr = 1;
          else if (m_p % PPN <= N) begin en = 1; tm = m_p % PPN - 1; end
          else wb = 1;
        end else if (m_p == BODY) begin
          cm = 1; nb = N - 1;
        end
      end
      M_DONE: dn = 1;
      default: ;
    endcase
    return {ini, clr, en, wb, cm, bsy, dn, m_to, SW'(nb), SW'(tm), IW'(m_iter)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {b.init, b.mac_clr, b.mac_en, b.wb_en, b.commit, b.busy, b.done, b.timeout,
            b.neuron_sel, b.term_sel, b.iter_cnt};
  endfunction

  int n_pass = 0, n_tot = 0;
  int rel, done_edge, n_en, n_clr, n_wb, n_cm, n_init;

  task automatic check_lit(input string name, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // One cycle: compare against the model on the falling edge, then count strobes after the rising edge.
  task automatic tick();
    logic [VW-1:0] g, e;
    @(negedge clk);
    g = dut_vec();
    e = model_vec();
    n_tot++;
    if (g === e) n_pass++;
    else $display("FAIL cycle_vec t=%0t: got %b, expected %b (init clr en wb commit busy done to nsel tsel iter)",
                  $time, g, e);
    @(posedge clk);
    #2;
    rel++;
    if (b.done && done_edge < 0) done_edge = rel;
    if (b.mac_en)  n_en++;
    if (b.mac_clr) n_clr++;
    if (b.wb_en)   n_wb++;
    if (b.commit)  n_cm++;
    if (b.init)    n_init++;
  endtask

  task automatic clear_stats();
    rel = 0; done_edge = -1; n_en = 0; n_clr = 0; n_wb = 0; n_cm = 0; n_init = 0;
  endtask

  task automatic finish_run(input string name, input int limit);
    while (done_edge < 0 && rel < limit) tick();
    if (done_edge < 0) check_lit({name, "_done_seen"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; b.start = 1'b1; b.converged = 1'b0;
    clear_stats();
    repeat (4) tick();
    check_lit("rst_busy", int'(b.busy), 0);
    check_lit("rst_init", int'(b.init), 0);
    check_lit("rst_vec", int'(dut_vec()), 0);
    b.start = 1'b0; rst = 1'b0;
    tick(); tick();

    // Single-iteration convergence.
    clear_stats();
    b.start = 1'b1; b.converged = 1'b1;
    tick();
    b.start = 1'b0;
    finish_run("conv1", 100);
    check_lit("conv1_done_edge", done_edge, 28);
    check_lit("conv1_iter", int'(b.iter_cnt), 1);
    check_lit("conv1_timeout", int'(b.timeout), 0);
    check_lit("conv1_mac_en", n_en, 16);
    check_lit("conv1_mac_clr", n_clr, 4);
    check_lit("conv1_wb", n_wb, 4);
    check_lit("conv1_commit", n_cm, 1);
    tick(); tick();

    // Convergence raised before the third CHECK; converged outside CHECK must be ignored.
    clear_stats();
    b.start = 1'b1; b.converged = 1'b0;
    tick();
    b.start = 1'b0;
    while (done_edge < 0 && rel < 200) begin
      if (rel == 55) b.converged = 1'b1;
      tick();
    end
    b.converged = 1'b0;
    check_lit("conv3_done_edge", done_edge, 80);
    check_lit("conv3_iter", int'(b.iter_cnt), 3);
    check_lit("conv3_commit", n_cm, 3);
    check_lit("conv3_timeout", int'(b.timeout), 0);
    tick(); tick();

    // Iteration cap.
    clear_stats();
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    finish_run("cap", 500);
    check_lit("cap_done_edge", done_edge, 392);
    check_lit("cap_iter", int'(b.iter_cnt), 15);
    check_lit("cap_commit", n_cm, 15);
    tick(); tick();
    check_lit("cap_timeout_held", int'(b.timeout), 1);
    check_lit("cap_iter_held", int'(b.iter_cnt), 15);

    // Five-cycle start, stray start mid-ACC, convergence on the capped CHECK.
    clear_stats();
    b.start = 1'b1;
    tick();
    check_lit("init_clears_timeout", int'(b.timeout), 0);
    check_lit("init_clears_iter", int'(b.iter_cnt), 0);
    repeat (4) tick();
    b.start = 1'b0;
    while (done_edge < 0 && rel < 500) begin
      if (rel == 10) b.start = 1'b1;
      if (rel == 11) b.start = 1'b0;
      if (rel == 395) b.converged = 1'b1;
      if (rel == 396) b.converged = 1'b0;
      tick();
    end
    b.converged = 1'b0;
    check_lit("long_init_cycles", n_init, 5);
    check_lit("simul_done_edge", done_edge, 396);
    check_lit("simul_iter", int'(b.iter_cnt), 15);
    check_lit("simul_timeout", int'(b.timeout), 0);
    tick(); tick();

    // Reset during ACC of neuron 2 in iteration 2.
    clear_stats();
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    while (rel < 42) tick();
    check_lit("pre_rst_iter", int'(b.iter_cnt), 1);
    rst = 1'b1;
    #1;
    check_lit("midrst_vec", int'(dut_vec()), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_stats();
    b.start = 1'b1; b.converged = 1'b1;
    tick();
    b.start = 1'b0;
    finish_run("rerun", 100);
    check_lit("rerun_done_edge", done_edge, 28);
    check_lit("rerun_iter", int'(b.iter_cnt), 1);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
